// File: rtl/ifetch_ctl.sv
// ifetch_ctl -- fetch-stage PC sequencer and instruction-fetch controller.
//
// Owns the architectural fetch PC, keeps at most one request outstanding to
// instruction memory and hands 32-bit instruction words to decode through a
// single-entry output register. A redirect from execute (bj_en/bj_pc) squashes
// the held instruction, retargets the PC and marks any in-flight response for
// discard. A redirect to a target with bit 1 set raises fetch_fault and parks
// the sequencer in FAULT until an aligned redirect arrives.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   bj_en, bj_pc             redirect pulse and target from execute
//   stall                    decode cannot accept; inst_* hold
//   req_valid/ready/addr     imem request handshake (addr word aligned)
//   rsp_valid, rsp_data      imem response, one per accepted request
//   inst_valid, inst, inst_pc instruction to decode
//   fetch_fault, fault_pc    misaligned-redirect pulse and offending target

module ifetch_ctl #(
  parameter int unsigned           XLEN     = 64,
  parameter logic [XLEN-1:0]       RESET_PC = 64'h0000_1000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            bj_en,
  input  logic [XLEN-1:0] bj_pc,
  input  logic            stall,
  output logic            req_valid,
  input  logic            req_ready,
  output logic [XLEN-1:0] req_addr,
  input  logic            rsp_valid,
  input  logic [31:0]     rsp_data,
  output logic            inst_valid,
  output logic [31:0]     inst,
  output logic [XLEN-1:0] inst_pc,
  output logic            fetch_fault,
  output logic [XLEN-1:0] fault_pc
);

  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_WAIT  = 2'd1,
    S_FAULT = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            drop_q, drop_d;        // in-flight response belongs to a squashed path
  logic            fpend_q, fpend_d;      // enter FAULT once the dropped response drains
  logic            hold_q, hold_d;        // request was offered but not yet accepted
  logic [XLEN-1:0] haddr_q, haddr_d;      // address frozen while a request is held
  logic            inst_valid_q, inst_valid_d;
  logic [31:0]     inst_q, inst_d;
  logic [XLEN-1:0] inst_pc_q, inst_pc_d;
  logic            fault_q, fault_d;
  logic [XLEN-1:0] fault_pc_q, fault_pc_d;

  logic slot_free;
  logic accept;
  logic misalign;
  logic busy_after;

  assign slot_free = ~inst_valid_q | ~stall;
  // Once offered, a request stays up (same address) until accepted, even if
  // the output slot fills or a redirect retargets the PC meanwhile.
  assign req_valid = ~rst & (state_q == S_REQ) & (hold_q | slot_free);
  assign req_addr  = hold_q ? haddr_q : pc_q;
  assign accept    = req_valid & req_ready;
  assign misalign  = bj_en & bj_pc[1];
  // A request is (or stays) in flight past this edge: offered in REQ, or
  // outstanding in WAIT with no response arriving now.
  assign busy_after = req_valid | ((state_q == S_WAIT) & ~rsp_valid);

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    drop_d       = drop_q;
    fpend_d      = fpend_q;
    hold_d       = req_valid & ~req_ready;
    haddr_d      = req_addr;
    inst_valid_d = inst_valid_q & stall;   // consumed unless decode stalls
    inst_d       = inst_q;
    inst_pc_d    = inst_pc_q;
    fault_d      = 1'b0;
    fault_pc_d   = fault_pc_q;

    unique case (state_q)
      S_REQ: begin
        if (accept) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (rsp_valid) begin
          if (drop_q) begin
            drop_d  = 1'b0;
            fpend_d = 1'b0;
            state_d = fpend_q ? S_FAULT : S_REQ;
          end else if (!bj_en) begin
            inst_d       = rsp_data;
            inst_pc_d    = pc_q;
            inst_valid_d = 1'b1;
            pc_d         = pc_q + XLEN'(4);
            state_d      = S_REQ;
          end else begin
            state_d = S_REQ;
          end
        end
      end
      S_FAULT: begin
        state_d = S_FAULT;
      end
      default: state_d = S_REQ;
    endcase

    // Redirect overrides everything above; the last one in a burst wins.
    if (bj_en) begin
      inst_valid_d = 1'b0;
      pc_d         = bj_pc;
      if (busy_after) begin
        drop_d  = 1'b1;
        fpend_d = misalign;
      end else begin
        drop_d  = 1'b0;
        fpend_d = 1'b0;
        state_d = misalign ? S_FAULT : S_REQ;
      end
      if (misalign) begin
        fault_d    = 1'b1;
        fault_pc_d = bj_pc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_REQ;
      pc_q         <= RESET_PC;
      drop_q       <= 1'b0;
      fpend_q      <= 1'b0;
      hold_q       <= 1'b0;
      haddr_q      <= RESET_PC;
      inst_valid_q <= 1'b0;
      inst_q       <= '0;
      inst_pc_q    <= '0;
      fault_q      <= 1'b0;
      fault_pc_q   <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      drop_q       <= drop_d;
      fpend_q      <= fpend_d;
      hold_q       <= hold_d;
      haddr_q      <= haddr_d;
      inst_valid_q <= inst_valid_d;
      inst_q       <= inst_d;
      inst_pc_q    <= inst_pc_d;
      fault_q      <= fault_d;
      fault_pc_q   <= fault_pc_d;
    end
  end

  assign inst_valid  = inst_valid_q;
  assign inst        = inst_q;
  assign inst_pc     = inst_pc_q;
  assign fetch_fault = fault_q;
  assign fault_pc    = fault_pc_q;

endmodule

// File: tb/tb_ifetch_ctl.sv
// tb_ifetch_ctl -- directed bench for ifetch_ctl with a latency-programmable
// imem model, a grant budget on req_ready, and scoreboards of expected request
// addresses and delivered instructions.

module tb_ifetch_ctl;

  logic        clk = 1'b0;
  logic        rst;
  logic        bj_en;
  logic [63:0] bj_pc;
  logic        stall;
  logic        req_valid;
  logic        req_ready;
  logic [63:0] req_addr;
  logic        rsp_valid = 1'b0;
  logic [31:0] rsp_data  = '0;
  logic        inst_valid;
  logic [31:0] inst;
  logic [63:0] inst_pc;
  logic        fetch_fault;
  logic [63:0] fault_pc;

  ifetch_ctl dut (
    .clk(clk), .rst(rst), .bj_en(bj_en), .bj_pc(bj_pc), .stall(stall),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc),
    .fetch_fault(fetch_fault), .fault_pc(fault_pc)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mk(input logic [63:0] a);
    return a[31:0] ^ {a[63:48], 16'h5A3C} ^ 32'hC0DE_0000;
  endfunction

  // imem model: answers each accepted request after mem_lat cycles
  int          mem_lat = 1;
  logic        m_busy  = 1'b0;
  int          m_cnt   = 0;
  logic [63:0] m_addr  = '0;

  always @(posedge clk) begin
    rsp_valid <= 1'b0;
    if (m_busy) begin
      if (m_cnt <= 1) begin
        rsp_valid <= 1'b1;
        rsp_data  <= mk(m_addr);
        m_busy    <= 1'b0;
      end else begin
        m_cnt <= m_cnt - 1;
      end
    end
    if (req_valid && req_ready) begin
      if (mem_lat <= 1) begin
        rsp_valid <= 1'b1;
        rsp_data  <= mk(req_addr);
      end else begin
        m_busy <= 1'b1;
        m_cnt  <= mem_lat - 1;
        m_addr <= req_addr;
      end
    end
  end

  int          n_chk = 0;
  int          n_err = 0;
  int          n_acc = 0;
  int          n_del = 0;
  int          limit = 0;
  int          cyc   = 0;
  logic [63:0] exp_req[$];
  logic [63:0] exp_inst[$];
  int          del_cyc[$];
  logic        prev_pend = 1'b0;
  logic [63:0] prev_addr = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Negedge monitor: request handshakes and decode deliveries
  task automatic mon();
    logic [63:0] e;
    if (rst) begin
      prev_pend = 1'b0;
    end else begin
      if (prev_pend) begin
        chk("hold_valid", {63'd0, req_valid}, 64'd1);
        chk("hold_addr", req_addr, prev_addr);
      end
      if (req_valid && req_ready) begin
        n_acc++;
        e = (exp_req.size() > 0) ? exp_req.pop_front() : ~req_addr;
        chk("req_addr", req_addr, e);
        $display("cyc %0d: request addr=0x%0h", cyc, req_addr);
      end
      prev_pend = req_valid && !req_ready;
      prev_addr = req_addr;
      if (inst_valid && !stall) begin
        n_del++;
        del_cyc.push_back(cyc);
        e = (exp_inst.size() > 0) ? exp_inst.pop_front() : ~inst_pc;
        chk("inst_pc", inst_pc, e);
        chk("inst", {32'd0, inst}, {32'd0, mk(e)});
        $display("cyc %0d: deliver pc=0x%0h inst=0x%0h", cyc, inst_pc, inst);
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    mon();
    @(posedge clk);
    #1;
    cyc++;
    req_ready = (n_acc < limit);
  endtask

  task automatic grant(input int n);
    limit     = n;
    req_ready = (n_acc < limit);
  endtask

  task automatic wait_del(input int n, input string tag);
    int b = 0;
    while (n_del < n && b < 60) begin tick(); b++; end
    chk(tag, 64'(n_del), 64'(n));
  endtask

  task automatic wait_acc(input int n, input string tag);
    int b = 0;
    while (n_acc < n && b < 60) begin tick(); b++; end
    chk(tag, 64'(n_acc), 64'(n));
  endtask

  task automatic redirect(input logic [63:0] pc);
    bj_en = 1'b1;
    bj_pc = pc;
    tick();
    bj_en = 1'b0;
  endtask

  initial begin
    rst = 1'b1; bj_en = 1'b0; bj_pc = '0; stall = 1'b0; req_ready = 1'b0;
    repeat (3) tick();
    // reset state
    chk("rst_req_valid", {63'd0, req_valid}, 64'd0);
    chk("rst_req_addr", req_addr, 64'h1000);
    chk("rst_inst_valid", {63'd0, inst_valid}, 64'd0);
    chk("rst_inst", {32'd0, inst}, 64'd0);
    chk("rst_inst_pc", inst_pc, 64'd0);
    chk("rst_fault", {63'd0, fetch_fault}, 64'd0);
    chk("rst_fault_pc", fault_pc, 64'd0);

    // 1: sequential fetch, one instruction every two cycles
    exp_req.push_back(64'h1000); exp_req.push_back(64'h1004); exp_req.push_back(64'h1008);
    exp_inst.push_back(64'h1000); exp_inst.push_back(64'h1004); exp_inst.push_back(64'h1008);
    limit = 3;
    rst = 1'b0;
    req_ready = (n_acc < limit);
    #1;
    chk("first_req_valid", {63'd0, req_valid}, 64'd1);
    chk("first_req_addr", req_addr, 64'h1000);
    wait_del(3, "seq_timeout");
    chk("rate_1", 64'(del_cyc[1] - del_cyc[0]), 64'd2);
    chk("rate_2", 64'(del_cyc[2] - del_cyc[1]), 64'd2);
    chk("pend_valid", {63'd0, req_valid}, 64'd1);
    chk("pend_addr", req_addr, 64'h100C);

    // 2: stall holds the instruction and blocks new requests
    stall = 1'b1;
    exp_req.push_back(64'h100C); exp_inst.push_back(64'h100C);
    grant(4);
    begin
      int b = 0;
      while (!inst_valid && b < 20) begin tick(); b++; end
    end
    chk("stall_load", {63'd0, inst_valid}, 64'd1);
    exp_req.push_back(64'h1010); exp_inst.push_back(64'h1010);
    grant(5);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_inst", {32'd0, inst}, {32'd0, mk(64'h100C)});
      chk("stall_pc", inst_pc, 64'h100C);
      chk("stall_noreq", {63'd0, req_valid}, 64'd0);
    end
    stall = 1'b0;
    wait_del(5, "resume_timeout");

    // 3: redirect while a request is outstanding
    mem_lat = 3;
    exp_req.push_back(64'h1014);
    grant(6);
    wait_acc(6, "wait_acc_timeout");
    redirect(64'h2000);
    mem_lat = 1;
    exp_req.push_back(64'h2000); exp_inst.push_back(64'h2000);
    grant(7);
    wait_del(6, "bj_wait_timeout");

    // 4: redirect while a request is offered but not accepted
    tick();
    chk("pend2_addr", req_addr, 64'h2004);
    redirect(64'h3000);
    tick();
    chk("bj_hold_addr", req_addr, 64'h2004);
    exp_req.push_back(64'h2004); exp_req.push_back(64'h3000); exp_inst.push_back(64'h3000);
    grant(9);
    wait_del(7, "bj_pend_timeout");

    // 5: misaligned redirect -> fault, idle until aligned redirect
    tick();
    redirect(64'h2002);
    chk("fault_pulse", {63'd0, fetch_fault}, 64'd1);
    chk("fault_pc", fault_pc, 64'h2002);
    tick();
    chk("fault_clear", {63'd0, fetch_fault}, 64'd0);
    exp_req.push_back(64'h3004);
    grant(11);
    repeat (8) tick();
    chk("fault_noreq_cnt", 64'(n_acc), 64'd10);
    chk("fault_noreq", {63'd0, req_valid}, 64'd0);
    chk("fault_pc_held", fault_pc, 64'h2002);
    exp_req.push_back(64'h4000); exp_inst.push_back(64'h4000);
    redirect(64'h4000);
    wait_del(8, "fault_exit_timeout");

    // 6: PC wrap, then redirect coincident with a response
    tick();
    exp_req.push_back(64'h4004); exp_req.push_back(64'hFFFF_FFFF_FFFF_FFFC); exp_req.push_back(64'h0);
    exp_inst.push_back(64'hFFFF_FFFF_FFFF_FFFC); exp_inst.push_back(64'h0);
    redirect(64'hFFFF_FFFF_FFFF_FFFC);
    grant(14);
    wait_del(10, "wrap_timeout");
    exp_req.push_back(64'h4);
    grant(15);
    wait_acc(15, "coinc_acc_timeout");
    redirect(64'h5000);
    exp_req.push_back(64'h5000); exp_inst.push_back(64'h5000);
    grant(16);
    wait_del(11, "coinc_timeout");

    // 7: reset mid-transaction; the late response must be ignored
    mem_lat = 3;
    exp_req.push_back(64'h5004);
    grant(17);
    wait_acc(17, "rst_acc_timeout");
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("rst2_inst_valid", {63'd0, inst_valid}, 64'd0);
      chk("rst2_req_addr", req_addr, 64'h1000);
    end

    chk("exp_req_empty", 64'(exp_req.size()), 64'd0);
    chk("exp_inst_empty", 64'(exp_inst.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end

endmodule
